// File: rtl/clock_divider_bank.sv
// Purpose: bank of N_CH programmable 50%-duty clock dividers with tick strobes and optional cascading.
// Latency: tick/clk_out are registered; a cascaded channel advances one cycle after its upstream tick.
// Backpressure: none; pause[i] freezes a channel (and anything cascaded from it), cfg writes never stall.
module clock_divider_bank #(
  parameter int                      N_CH     = 4,
  parameter int                      CNT_W    = 27,
  parameter logic [N_CH*CNT_W-1:0]   DEF_HALF = {27'd200_000, 27'd25_000_000, 27'd50_000_000, 27'd5},
  parameter logic [N_CH-1:0]         CASCADE  = 4'b1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic [N_CH-1:0]   pause,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   active
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [CNT_W-1:0] RST_HALF = DEF_HALF[g*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             up;
    logic             adv;
    logic             cfg_hit;

    // Advance source: free-running on clk, or the previous channel's registered tick.
    if (g == 0) begin : g_root
      assign up = 1'b1;
    end else if (CASCADE[g]) begin : g_casc
      assign up = tick[g-1];
    end else begin : g_free
      assign up = 1'b1;
    end

    assign adv     = up && !pause[g];
    assign cfg_hit = cfg_we && (cfg_ch == 3'(g));

    // Next-state: sync clear, stopped-channel reload, wrap with shadow load, or count.
    always_comb begin
      shd_d  = shd_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      if (cfg_hit) begin
        shd_d = cfg_half;
      end
      if (sync_clr) begin
        // Phase alignment: pending (or same-cycle) shadow values apply at once.
        half_d = shd_d;
        cnt_d  = '0;
        clk_d  = 1'b0;
      end else if (half_q == '0) begin
        // Stopped channel: a write restarts it directly from cnt=0.
        if (cfg_hit) begin
          half_d = cfg_half;
        end
        cnt_d = '0;
        clk_d = 1'b0;
      end else if (adv) begin
        if (cnt_q == half_q - CNT_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          half_d = shd_d;
          // Loading zero parks the output low instead of toggling.
          clk_d  = (shd_d == '0) ? 1'b0 : ~clk_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Channel state registers; reset restores the default half-period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        half_q <= RST_HALF;
        shd_q  <= RST_HALF;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        half_q <= half_d;
        shd_q  <= shd_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign active[g]  = (half_q != '0);
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
`timescale 1ns/1ps
// Bench for clock_divider_bank: directed scenarios plus random traffic against a countdown reference model.
module tb_clock_divider_bank;
  localparam int                    N_CH  = 4;
  localparam int                    CNT_W = 8;
  localparam logic [N_CH*CNT_W-1:0] DEF   = {8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [N_CH-1:0]       CASC  = 4'b1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sync_clr = 1'b0;
  logic [N_CH-1:0]  pause = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [N_CH-1:0]  clk_out, tick, active;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: half-period, shadow, advances left until the next wrap, outputs.
  int m_half [N_CH];
  int m_shd  [N_CH];
  int m_left [N_CH];
  bit m_clk  [N_CH];
  bit m_tick [N_CH];

  int cyc = 0;
  int last [N_CH];
  int ivl  [N_CH];

  always #5 clk = ~clk;

  clock_divider_bank #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_HALF(DEF), .CASCADE(CASC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .pause(pause),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
    .clk_out(clk_out), .tick(tick), .active(active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_half[c] = int'(DEF[c*CNT_W +: CNT_W]);
      m_shd[c]  = m_half[c];
      m_left[c] = m_half[c];
      m_clk[c]  = 1'b0;
      m_tick[c] = 1'b0;
    end
  endfunction

  // One rising edge of the model, using the inputs presented to the DUT at that edge.
  function automatic void model_edge();
    bit prev [N_CH];
    bit go;
    for (int c = 0; c < N_CH; c++) prev[c] = m_tick[c];
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_we && int'(cfg_ch) == c) m_shd[c] = int'(cfg_half);
      m_tick[c] = 1'b0;
      if (sync_clr) begin
        m_half[c] = m_shd[c];
        m_left[c] = m_half[c];
        m_clk[c]  = 1'b0;
      end else if (m_half[c] == 0) begin
        if (cfg_we && int'(cfg_ch) == c) m_half[c] = int'(cfg_half);
        m_left[c] = m_half[c];
        m_clk[c]  = 1'b0;
      end else begin
        go = ((c == 0) || !CASC[c]) ? 1'b1 : prev[c-1];
        if (pause[c]) go = 1'b0;
        if (go) begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            m_tick[c] = 1'b1;
            m_half[c] = m_shd[c];
            m_left[c] = m_half[c];
            m_clk[c]  = (m_half[c] == 0) ? 1'b0 : !m_clk[c];
          end
        end
      end
    end
  endfunction

  function automatic logic [N_CH-1:0] vec_clk();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_clk[c];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] vec_tick();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_tick[c];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] vec_act();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = (m_half[c] != 0);
    return v;
  endfunction

  function automatic void clear_ivl();
    for (int c = 0; c < N_CH; c++) begin
      last[c] = -1;
      ivl[c]  = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("clk_out", 32'(clk_out), 32'(vec_clk()));
    chk("tick", 32'(tick), 32'(vec_tick()));
    chk("active", 32'(active), 32'(vec_act()));
    for (int c = 0; c < N_CH; c++) begin
      if (tick[c]) begin
        if (last[c] >= 0) ivl[c] = cyc - last[c];
        last[c] = cyc;
      end
    end
  endtask

  task automatic cfg(input int ch, input int h);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_half = 8'(h);
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int n;
    int n2;
    int n3;
    logic frz;
    model_reset();
    clear_ivl();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_active", 32'(active), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Default periods and cascade
    clear_ivl();
    repeat (70) step();
    chk("ivl_ch0", 32'(ivl[0]), 32'd1);
    chk("ivl_ch1", 32'(ivl[1]), 32'd2);
    chk("ivl_ch2", 32'(ivl[2]), 32'd3);
    chk("ivl_ch3", 32'(ivl[3]), 32'd15);

    // Reprogram ch1 mid-count
    step();
    cfg(1, 4);
    clear_ivl();
    repeat (30) step();
    chk("ivl_ch1_h4", 32'(ivl[1]), 32'd4);

    // Stop ch2, then restart it with 7
    cfg(2, 0);
    repeat (10) step();
    chk("ch2_stop_active", 32'(active[2]), 32'd0);
    chk("ch2_stop_clk", 32'(clk_out[2]), 32'd0);
    cfg(2, 7);
    n = 0;
    while (n < 20 && !tick[2]) begin
      step();
      n++;
    end
    chk("ch2_restart_lat", 32'(n), 32'd7);

    // Pause ch2 for 10 cycles
    repeat (5) step();
    frz = clk_out[2];
    pause = 4'b0100;
    n2 = 0;
    n3 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick[2]) n2++;
      if (i > 0 && tick[3]) n3++;
      chk("pause_clk2", 32'(clk_out[2]), 32'(frz));
    end
    chk("pause_ticks2", 32'(n2), 32'd0);
    chk("pause_ticks3", 32'(n3), 32'd0);
    pause = '0;
    repeat (20) step();

    // sync_clr with a same-cycle write to ch1, then an out-of-range write
    sync_clr = 1'b1;
    cfg_we   = 1'b1;
    cfg_ch   = 3'd1;
    cfg_half = 8'd6;
    step();
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    chk("sclr_clk_out", 32'(clk_out), 32'h0);
    chk("sclr_tick", 32'(tick), 32'h0);
    cfg_we   = 1'b1;
    cfg_ch   = 3'd5;
    cfg_half = 8'd9;
    n = 0;
    while (n < 20 && !tick[1]) begin
      step();
      cfg_we = 1'b0;
      n++;
    end
    chk("sclr_ch1_lat", 32'(n), 32'd6);
    chk("bad_ch_active", 32'(active), 32'hF);
    repeat (20) step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      pause    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      sync_clr = ($urandom_range(0, 199) == 0);
      cfg_we   = ($urandom_range(0, 19) == 0);
      cfg_ch   = 3'($urandom_range(0, 7));
      cfg_half = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      step();
    end
    pause    = '0;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;

    // Asynchronous reset between edges
    sync_clr = 1'b1;
    cfg(0, 1);
    sync_clr = 1'b0;
    repeat (5) step();
    chk("pre_rst_tick0", 32'(tick[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_active", 32'(active), 32'hF);
    model_reset();
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    clear_ivl();
    repeat (40) step();
    chk("post_rst_ivl0", 32'(ivl[0]), 32'd1);
    chk("post_rst_ivl1", 32'(ivl[1]), 32'd2);
    chk("post_rst_ivl2", 32'(ivl[2]), 32'd3);
    chk("post_rst_ivl3", 32'(ivl[3]), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
